// File: rtl/eq_pkg.sv
// Shared equalizer definitions: the default FIR length and the sequencing FSM states.
// The sample queue, the coefficient ROMs and the FIR MAC controller all use them.
package eq_pkg;

    localparam int unsigned EQ_NUM_TAPS = 32'd1021;
    localparam int unsigned EQ_ADDR_W   = 32'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: walks the coefficient ROM in lock-step with the sample queue read
// pointer, strobes the MAC accumulators and flags a result once NUM_TAPS products are summed.
module fir_seq_ctrl
    import eq_pkg::*;
#(
    parameter int unsigned NUM_TAPS = EQ_NUM_TAPS,
    parameter int unsigned ADDR_W   = EQ_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sequencing,
    input  logic              wrt_smpl,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              res_vld,
    output logic              busy,
    output logic              err,
    output logic              ovr
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(32'd0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 32'd1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [ADDR_W-1:0] coeff_addr_q, coeff_addr_d;
    logic              acc_en_q, acc_en_d;
    logic              res_vld_q, res_vld_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;
    logic              start_s;
    logic              issue_s;

    // Next-state logic: tap issue, address/counter advance and sticky flag updates.
    always_comb begin
        state_d      = state_q;
        tap_cnt_d    = tap_cnt_q;
        coeff_addr_d = coeff_addr_q;
        err_d        = err_q;
        start_s      = 1'b0;
        issue_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sequencing) begin
                    start_s      = 1'b1;
                    issue_s      = 1'b1;
                    coeff_addr_d = ADDR_ONE;
                    tap_cnt_d    = ADDR_ONE;
                    err_d        = 1'b0;
                    if (NUM_TAPS == 32'd1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_MAC;
                    end
                end else begin
                    coeff_addr_d = ADDR_ZERO;
                    tap_cnt_d    = ADDR_ZERO;
                end
            end
            ST_MAC: begin
                if (sequencing) begin
                    issue_s      = 1'b1;
                    coeff_addr_d = coeff_addr_q + ADDR_ONE;
                    tap_cnt_d    = tap_cnt_q + ADDR_ONE;
                    if (tap_cnt_q == LAST_TAP) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_MAC;
                    end
                end else begin
                    // Window closed before all taps were issued: abandon the partial sum.
                    err_d        = 1'b1;
                    coeff_addr_d = ADDR_ZERO;
                    tap_cnt_d    = ADDR_ZERO;
                    state_d      = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                coeff_addr_d = ADDR_ZERO;
                tap_cnt_d    = ADDR_ZERO;
                if (sequencing) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (sequencing) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                coeff_addr_d = ADDR_ZERO;
                tap_cnt_d    = ADDR_ZERO;
                state_d      = ST_IDLE;
            end
        endcase

        // A write coinciding with the clear still counts as an overrun.
        if (start_s) begin
            ovr_d = wrt_smpl;
        end else if (state_q != ST_IDLE) begin
            ovr_d = ovr_q | wrt_smpl;
        end else begin
            ovr_d = ovr_q;
        end

        acc_en_d  = issue_s;
        res_vld_d = (state_q == ST_DRAIN);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tap_cnt_q    <= ADDR_ZERO;
            coeff_addr_q <= ADDR_ZERO;
            acc_en_q     <= 1'b0;
            res_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_cnt_q    <= tap_cnt_d;
            coeff_addr_q <= coeff_addr_d;
            acc_en_q     <= acc_en_d;
            res_vld_q    <= res_vld_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

    // The clear must land in the same cycle as tap 0, so it stays combinational.
    assign acc_clr    = start_s & rst_n;
    assign coeff_addr = coeff_addr_q;
    assign acc_en     = acc_en_q;
    assign res_vld    = res_vld_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign ovr        = ovr_q;

endmodule
